// File: rtl/ex_stage.sv
// Execute stage: combinational ALU with NZCV flag generation, EX/MEM pipeline
// register, registered status flags and combinational branch resolution.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        freeze,
    input  logic [3:0]  exe_cmd,
    input  logic        wb_en_in,
    input  logic        mem_r_in,
    input  logic        mem_w_in,
    input  logic        s_in,
    input  logic        b_in,
    input  logic [31:0] val_rn,
    input  logic [31:0] val2,
    input  logic [31:0] val_rm,
    input  logic [3:0]  dest_in,
    input  logic [31:0] pc_in,
    input  logic [23:0] imm24,
    output logic [31:0] alu_res,
    output logic [31:0] st_val,
    output logic [3:0]  dest,
    output logic        wb_en,
    output logic        mem_r,
    output logic        mem_w,
    output logic [3:0]  status,
    output logic        br_taken,
    output logic [31:0] br_addr
);

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    logic        c_flag;
    logic [32:0] sum;
    logic [31:0] res;
    logic        is_add;
    logic        is_sub;
    logic        c_new;
    logic        v_new;

    assign c_flag = status[1];

    always_comb begin
        sum    = '0;
        res    = '0;
        is_add = 1'b0;
        is_sub = 1'b0;
        case (exe_cmd)
            CMD_MOV: res = val2;
            CMD_MVN: res = ~val2;
            CMD_ADD: begin
                sum    = {1'b0, val_rn} + {1'b0, val2};
                is_add = 1'b1;
            end
            CMD_ADC: begin
                sum    = {1'b0, val_rn} + {1'b0, val2} + {32'b0, c_flag};
                is_add = 1'b1;
            end
            // Subtract as rn + ~val2 + 1 so bit 32 is directly NOT borrow.
            CMD_SUB: begin
                sum    = {1'b0, val_rn} + {1'b0, ~val2} + 33'd1;
                is_sub = 1'b1;
            end
            CMD_SBC: begin
                sum    = {1'b0, val_rn} + {1'b0, ~val2} + {32'b0, c_flag};
                is_sub = 1'b1;
            end
            CMD_AND: res = val_rn & val2;
            CMD_ORR: res = val_rn | val2;
            CMD_EOR: res = val_rn ^ val2;
            default: res = '0;
        endcase
        if (is_add || is_sub) begin
            res = sum[31:0];
        end
    end

    always_comb begin
        c_new = status[1];
        v_new = status[0];
        if (is_add) begin
            c_new = sum[32];
            v_new = (val_rn[31] == val2[31]) && (res[31] != val_rn[31]);
        end else if (is_sub) begin
            c_new = sum[32];
            v_new = (val_rn[31] != val2[31]) && (res[31] != val_rn[31]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_res <= '0;
            st_val  <= '0;
            dest    <= '0;
            wb_en   <= 1'b0;
            mem_r   <= 1'b0;
            mem_w   <= 1'b0;
            status  <= '0;
        end else if (!freeze) begin
            alu_res <= res;
            st_val  <= val_rm;
            dest    <= dest_in;
            wb_en   <= in_valid & wb_en_in;
            mem_r   <= in_valid & mem_r_in;
            mem_w   <= in_valid & mem_w_in;
            if (in_valid && s_in) begin
                status <= {res[31], (res == 32'd0), c_new, v_new};
            end
        end
    end

    assign br_taken = in_valid & b_in & ~freeze;
    assign br_addr  = pc_in + {{6{imm24[23]}}, imm24, 2'b00};

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 in_valid  in  1  current ID/EX contents hold a real instruction.
REQ-004 freeze  in  1  hazard stall; holds all state.
REQ-005 exe_cmd  in  4  ALU command: MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000; other codes are NOP (result 0).
REQ-006 wb_en_in, mem_r_in, mem_w_in, s_in, b_in  in  1 each  control bits from decode.
REQ-007 val_rn  in  32  first operand; val2  in  32  second operand, already shifted or immediate.
REQ-008 val_rm  in  32  store data; dest_in  in  4  destination register.
REQ-009 pc_in  in  32  PC+4 of the instruction; imm24  in  24  signed branch offset in words.
REQ-010 alu_res  out  32, st_val  out  32, dest  out  4, wb_en/mem_r/mem_w  out  1 each  EX/MEM register outputs.
REQ-011 status  out  4  {N,Z,C,V} status register.
REQ-012 br_taken  out  1, br_addr  out  32  combinational branch resolution.

Function
REQ-013 ALU is combinational; EX/MEM register captures its result and control bits, so alu_res is valid 1 cycle after issue.
REQ-014 MOV=val2; MVN=~val2; ADD=rn+val2; ADC=rn+val2+C; SUB=rn-val2; SBC=rn-val2-(~C); AND/ORR/EOR bitwise. C is the registered status C.
REQ-015 Arithmetic is 33-bit: for ADD/ADC, carry = bit 32; for SUB/SBC, carry = NOT borrow (1 when no borrow).
REQ-016 V = operand signs equal and result sign differs (add); operand signs differ and result sign differs from rn (subtract).
REQ-017 N = result[31]; Z = (result == 0).
REQ-018 Logical/move commands leave the stored C and V unchanged and update only N and Z.
REQ-019 status updates on the edge when in_valid && s_in && !freeze && !rst; otherwise status holds.
REQ-020 CMP/TST are issued as SUB/AND with wb_en_in=0 and s_in=1; no special handling.
REQ-021 Memory operations: exe_cmd=ADD yields the address; st_val registers val_rm.
REQ-022 If in_valid=0, the EX/MEM register loads wb_en=mem_r=mem_w=0 (bubble); data fields may take any value.
REQ-023 freeze=1: EX/MEM register and status hold their values; br_taken is forced 0.
REQ-024 br_taken = in_valid && b_in && !freeze; br_addr = pc_in + (sign-extended imm24 << 2), computed in 32 bits with wrap-around.
REQ-025 Condition-code checking belongs to decode; b_in arrives already qualified.
REQ-026 ADC and SUB in back-to-back cycles: the second instruction uses C written by the first (status is registered, no bypass required beyond the register).

Reset
REQ-027 While rst=1 at an edge: status=0000, alu_res=0, st_val=0, dest=0, wb_en=mem_r=mem_w=0.
REQ-028 rst takes priority over freeze and in_valid; br_taken stays combinational but the instruction is discarded.
REQ-029 After rst deasserts, the first valid instruction behaves as if C=0.

Verification
REQ-030 ADD rn=0xFFFFFFFF, val2=1, s=1 -> next cycle alu_res=0, status=0110 (Z,C).
REQ-031 SUB rn=0x80000000, val2=1, s=1 -> alu_res=0x7FFFFFFF, status=0011 (C,V); then ADC rn=1, val2=1 -> alu_res=3.
REQ-032 MVN val2=0 with s=1 after status=0011 -> alu_res=0xFFFFFFFF, status=1011 (C,V kept).
REQ-033 b_in=1, pc_in=0x100, imm24=0xFFFFFE -> br_taken=1, br_addr=0xF8; same with freeze=1 -> br_taken=0 and EX/MEM unchanged.
REQ-034 STR: exe_cmd=ADD, rn=0x40, val2=8, val_rm=0xDEADBEEF, mem_w_in=1 -> alu_res=0x48, st_val=0xDEADBEEF, mem_w=1; in_valid=0 next cycle -> mem_w=0.
REQ-035 rst asserted mid-sequence with status=1111 -> next edge all outputs 0 and status=0000 despite in_valid=1.
